// File: rtl/osd_pkg.sv
// Shared constants, command encodings and FSM state type for the OSD SPI command path.
package osd_pkg;

    localparam int unsigned OSD_LINES  = 8;
    localparam int unsigned LINE_W     = $clog2(OSD_LINES);
    localparam int unsigned LINE_LEN   = 256;
    localparam int unsigned COL_W      = $clog2(LINE_LEN);
    localparam int unsigned ADDR_W     = LINE_W + COL_W;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = $clog2(BYTE_W);
    localparam int unsigned SYNC_DEPTH = 2;

    localparam logic [2:0] CMD_WRITE  = 3'b001;
    localparam logic [2:0] CMD_ENABLE = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        SKIP = 2'd3
    } osd_state_t;

    // Opcode field of a command byte.
    function automatic logic [2:0] cmd_op(input logic [BYTE_W-1:0] cmd);
        return cmd[7:5];
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronises SCK/SS/DI into clk_sys and assembles MSB-first bytes.
module spi_byte_rx
    import osd_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              spi_sck,
    input  logic              spi_ss_n,
    input  logic              spi_di,
    output logic              byte_done,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              ss_fall,
    output logic              ss_rise,
    output logic              ss_active
);

    logic [SYNC_DEPTH-1:0] sck_sync;
    logic [SYNC_DEPTH-1:0] ss_sync;
    logic [SYNC_DEPTH-1:0] di_sync;
    logic                  sck_d;
    logic                  ss_d;
    logic                  in_frame;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0]     sr;

    logic sck_s_c;
    logic ss_s_c;
    logic di_s_c;
    logic sck_rise_c;
    logic ss_fall_c;
    logic ss_rise_c;
    logic shift_c;

    assign sck_s_c = sck_sync[SYNC_DEPTH-1];
    assign ss_s_c  = ss_sync[SYNC_DEPTH-1];
    assign di_s_c  = di_sync[SYNC_DEPTH-1];

    // Edges from the synchronised value and its registered copy. A fall is only
    // seen after SS has been observed high, so a line already low out of reset
    // never opens a frame; a rise only matters for an open frame.
    assign sck_rise_c = sck_s_c & ~sck_d;
    assign ss_fall_c  = ss_d & ~ss_s_c;
    assign ss_rise_c  = ss_s_c & ~ss_d & in_frame;
    assign shift_c    = sck_rise_c & in_frame;

    assign ss_active = in_frame;

    // Two-flop synchronisers plus the delayed copies used for edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync <= '0;
            ss_sync  <= '0;
            di_sync  <= '0;
            sck_d    <= 1'b0;
            ss_d     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_DEPTH-2:0], spi_sck};
            ss_sync  <= {ss_sync[SYNC_DEPTH-2:0], spi_ss_n};
            di_sync  <= {di_sync[SYNC_DEPTH-2:0], spi_di};
            sck_d    <= sck_s_c;
            ss_d     <= ss_s_c;
        end
    end

    // Frame tracking, bit counter, shift register and registered byte/edge strobes.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            in_frame  <= 1'b0;
            bit_cnt   <= '0;
            sr        <= '0;
            byte_done <= 1'b0;
            rx_byte   <= '0;
            ss_fall   <= 1'b0;
            ss_rise   <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            ss_fall   <= ss_fall_c;
            ss_rise   <= ss_rise_c;

            if (ss_fall_c) begin
                in_frame <= 1'b1;
            end else if (ss_rise_c) begin
                in_frame <= 1'b0;
            end

            // A clock edge landing with the closing SS edge still belongs to the frame.
            if (shift_c) begin
                sr      <= {sr[BYTE_W-2:0], di_s_c};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
                    byte_done <= 1'b1;
                    rx_byte   <= {sr[BYTE_W-2:0], di_s_c};
                end
            end

            // Either SS edge discards any partial byte.
            if (ss_fall_c || ss_rise_c) begin
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/osd_spi_ctrl.sv
// OSD SPI command decoder: turns received bytes into frame-buffer writes and the overlay enable.
module osd_spi_ctrl #(
    parameter int unsigned OSD_LINES  = osd_pkg::OSD_LINES,
    parameter logic [2:0]  CMD_WRITE  = osd_pkg::CMD_WRITE,
    parameter logic [2:0]  CMD_ENABLE = osd_pkg::CMD_ENABLE
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    input  logic                            SPI_SCK,
    input  logic                            SPI_SS3,
    input  logic                            SPI_DI,
    output logic                            osd_enable,
    output logic                            buf_we,
    output logic [$clog2(OSD_LINES)+7:0]    buf_addr,
    output logic [7:0]                      buf_data,
    output logic                            cmd_valid,
    output logic [7:0]                      cmd_byte,
    output logic                            busy
);

    import osd_pkg::osd_state_t;
    import osd_pkg::IDLE;
    import osd_pkg::CMD;
    import osd_pkg::DATA;
    import osd_pkg::SKIP;
    import osd_pkg::BYTE_W;
    import osd_pkg::COL_W;
    import osd_pkg::cmd_op;

    localparam int unsigned LINE_W = $clog2(OSD_LINES);

    logic              rx_done;
    logic [BYTE_W-1:0] rx_byte;
    logic              rx_ss_fall;
    logic              rx_ss_rise;
    logic              rx_active;

    osd_state_t        state;
    logic [LINE_W-1:0] line;
    logic [COL_W-1:0]  col;

    // Serial front end: synchronisers, edge detection and byte assembly.
    spi_byte_rx u_rx (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .spi_sck   (SPI_SCK),
        .spi_ss_n  (SPI_SS3),
        .spi_di    (SPI_DI),
        .byte_done (rx_done),
        .rx_byte   (rx_byte),
        .ss_fall   (rx_ss_fall),
        .ss_rise   (rx_ss_rise),
        .ss_active (rx_active)
    );

    // Command FSM with line/column counters and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            line       <= '0;
            col        <= '0;
            osd_enable <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            busy       <= 1'b0;
        end else begin
            buf_we    <= 1'b0;
            cmd_valid <= 1'b0;
            busy      <= rx_active;

            case (state)
                IDLE: begin
                    if (rx_ss_fall) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (rx_done) begin
                        cmd_valid <= 1'b1;
                        cmd_byte  <= rx_byte;
                        if (cmd_op(rx_byte) == CMD_WRITE) begin
                            line  <= rx_byte[LINE_W-1:0];
                            col   <= '0;
                            state <= DATA;
                        end else if (cmd_op(rx_byte) == CMD_ENABLE) begin
                            osd_enable <= rx_byte[0];
                            state      <= SKIP;
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                DATA: begin
                    // Column wraps within the addressed line; the line never advances.
                    if (rx_done) begin
                        buf_we   <= 1'b1;
                        buf_addr <= {line, col};
                        buf_data <= rx_byte;
                        col      <= col + COL_W'(1);
                    end
                end
                SKIP: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Frame end wins last, after any byte completing in the same cycle.
            if (rx_ss_rise) begin
                state <= IDLE;
            end
        end
    end

endmodule
